// File: rtl/cpu_pkg.sv
// Shared CPU types: ALU opcodes and the dispatcher state encoding.
package cpu_pkg;

  localparam int unsigned REG_SIZE_DEF       = 8;
  localparam int unsigned RD_WIDTH_DEF       = 5;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESULT = 2'd2,
    ERROR  = 2'd3
  } dispatch_state_e;

endpackage

// File: rtl/alu_dispatch_if.sv
// Decode, ALU and writeback handshakes seen by the ALU dispatcher.
interface alu_dispatch_if
  import cpu_pkg::*;
#(
  parameter int unsigned REG_SIZE = REG_SIZE_DEF,
  parameter int unsigned RD_WIDTH = RD_WIDTH_DEF
);

  logic                dec_valid;
  logic                dec_ready;
  alu_op_e             dec_op;
  logic [REG_SIZE-1:0] dec_op1;
  logic [REG_SIZE-1:0] dec_op2;
  logic [RD_WIDTH-1:0] dec_rd;

  alu_op_e             alu_operation;
  logic [REG_SIZE-1:0] alu_op1;
  logic [REG_SIZE-1:0] alu_op2;
  logic                alu_req;
  logic                alu_done;
  logic [REG_SIZE-1:0] alu_res;

  logic                wb_valid;
  logic                wb_ready;
  logic [REG_SIZE-1:0] wb_data;
  logic [RD_WIDTH-1:0] wb_rd;
  logic                wb_err;

  logic                busy;

  // Dispatcher side
  modport master (
    input  dec_valid, dec_op, dec_op1, dec_op2, dec_rd,
    output dec_ready,
    output alu_operation, alu_op1, alu_op2, alu_req,
    input  alu_done, alu_res,
    output wb_valid, wb_data, wb_rd, wb_err,
    input  wb_ready,
    output busy
  );

  // Surrounding decode / ALU / writeback side
  modport slave (
    output dec_valid, dec_op, dec_op1, dec_op2, dec_rd,
    input  dec_ready,
    input  alu_operation, alu_op1, alu_op2, alu_req,
    output alu_done, alu_res,
    input  wb_valid, wb_data, wb_rd, wb_err,
    output wb_ready,
    input  busy
  );

endinterface

// File: rtl/alu_dispatch.sv
// Requester side of the ALU req/done handshake: issues one decoded op, waits for
// completion or timeout, and holds the result for writeback.
module alu_dispatch
  import cpu_pkg::*;
#(
  parameter int unsigned REG_SIZE       = REG_SIZE_DEF,
  parameter int unsigned RD_WIDTH       = RD_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  alu_dispatch_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dispatch_state_e     state_q, state_d;
  alu_op_e             op_q;
  logic [REG_SIZE-1:0] op1_q;
  logic [REG_SIZE-1:0] op2_q;
  logic [RD_WIDTH-1:0] rd_q;
  logic [REG_SIZE-1:0] res_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                req_q;
  logic                timeout;

  assign timeout = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Done has priority over timeout when both land in the same ISSUE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.dec_valid) state_d = ISSUE;
      ISSUE: begin
        if (bus.alu_done)  state_d = RESULT;
        else if (timeout)  state_d = ERROR;
      end
      RESULT: if (bus.wb_ready) state_d = IDLE;
      ERROR:  if (bus.wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand/tag capture, request line, timeout counter and result buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= ALU_ADD;
      op1_q <= '0;
      op2_q <= '0;
      rd_q  <= '0;
      req_q <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.dec_valid) begin
            op_q  <= bus.dec_op;
            op1_q <= bus.dec_op1;
            op2_q <= bus.dec_op2;
            rd_q  <= bus.dec_rd;
            req_q <= 1'b1;
            cnt_q <= '0;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus.alu_done) begin
            res_q <= bus.alu_res;
            req_q <= 1'b0;
          end else if (timeout) begin
            res_q <= '0;
            req_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_operation = op_q;
  assign bus.alu_op1       = op1_q;
  assign bus.alu_op2       = op2_q;
  assign bus.alu_req       = req_q;
  assign bus.wb_data       = res_q;
  assign bus.wb_rd         = rd_q;

  // Handshake status decoded straight from state
  assign bus.dec_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.wb_valid  = (state_q == RESULT) || (state_q == ERROR);
  assign bus.wb_err    = (state_q == ERROR);

endmodule
